motor_sequencer: RTL and testbench

Sequencing controller for the two-motor H-bridge drive. It turns the switch command into a ramped 12-bit duty word for the `pwm` block, plus `IN`/`EN` bridge controls for the `switch` block. Direction changes go through a ramp-down and dead-time. Overcurrent (`OC`) triggers a timed fault, retries, and lockout after repeated faults. It sits between `sw` and the existing `pwm`/`switch` datapath and exports its state code for `sevenSeg`.

---
 rtl/motor_sequencer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_motor_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : motor_sequencer
//  Description : Two-motor H-bridge sequencing controller. Converts the
//                switch command into a ramped 12-bit duty word plus bridge
//                IN/EN controls. Direction changes pass through a ramp-down
//                and a dead-time. Overcurrent causes a timed fault with
//                retry counting and a final lockout.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_sequencer #(
    parameter int RAMP_DIV    = 10000,
    parameter int RAMP_STEP   = 16,
    parameter int DEAD_CYCLES = 1000000,
    parameter int FAULT_HOLD  = 100000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic [1:0]  OC,
    output logic [11:0] duty,
    output logic [3:0]  IN,
    output logic [1:0]  EN,
    output logic [2:0]  state,
    output logic        fault,
    output logic [1:0]  retry_cnt
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int TICK_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TIMER_MAX = (DEAD_CYCLES > FAULT_HOLD) ? DEAD_CYCLES : FAULT_HOLD;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TICK_W-1:0]  c_tick_last  = TICK_W'(RAMP_DIV - 1);
    localparam logic [TIMER_W-1:0] c_dead_last  = TIMER_W'(DEAD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_fault_last = TIMER_W'(FAULT_HOLD - 1);
    localparam logic [1:0]         c_retry_max  = 2'(MAX_RETRY);
    localparam logic [11:0]        c_step12     = 12'(RAMP_STEP);
    localparam logic [12:0]        c_step13     = 13'(RAMP_STEP);

    // State codes double as the display code exported on 'state'.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRIVE    = 3'd1,
        S_STOPPING = 3'd2,
        S_DEAD     = 3'd3,
        S_FAULT    = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [11:0]          r_duty;
    logic [1:0]           r_dir_q;
    logic [TIMER_W-1:0]   r_timer;
    logic [1:0]           r_retry;
    logic [3:0]           r_in;
    logic [1:0]           r_en;
    logic                 r_fault;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [1:0]           r_oc_meta;
    logic [1:0]           r_oc_s;

    // ------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------
    state_t               w_state_nx;
    logic [11:0]          w_duty_nx;
    logic [1:0]           w_dir_nx;
    logic [TIMER_W-1:0]   w_timer_nx;
    logic [1:0]           w_retry_nx;
    logic [3:0]           w_in_nx;
    logic [1:0]           w_en_nx;
    logic                 w_fault_nx;

    logic                 w_run;
    logic                 w_tick;
    logic                 w_oc_any;
    logic [11:0]          w_target;
    logic [11:0]          w_tgt;
    logic [11:0]          w_ramp_duty;
    logic                 w_unused;

    // sw[3] has no function in the command word.
    assign w_unused = sw[3];

    assign w_run    = sw[2];
    assign w_oc_any = |r_oc_s;
    assign w_tick   = (r_tick_cnt == c_tick_last);

    // speed * 255 computed as (speed << 8) - speed; max 3825 fits 12 bits.
    assign w_target = w_run ? ({sw[7:4], 8'h00} - {8'h00, sw[7:4]}) : 12'd0;

    // While stopping the ramp always heads for zero.
    assign w_tgt = (r_state == S_STOPPING) ? 12'd0 : w_target;

    // One ramp step toward tgt, clamped so it never overshoots or wraps.
    function automatic logic [11:0] ramp_next(input logic [11:0] cur,
                                              input logic [11:0] tgt);
        logic [12:0] up;
        logic [11:0] gap;
        up        = {1'b0, cur} + c_step13;
        gap       = cur - tgt;
        ramp_next = cur;
        if (cur < tgt) begin
            ramp_next = (up > {1'b0, tgt}) ? tgt : up[11:0];
        end else if (cur > tgt) begin
            ramp_next = (gap <= c_step12) ? tgt : (cur - c_step12);
        end
    endfunction

    assign w_ramp_duty = ramp_next(r_duty, w_tgt);

    // Per-motor bridge input pair: 10 forward, 01 reverse.
    function automatic logic [1:0] bridge_pair(input logic fwd);
        bridge_pair = fwd ? 2'b10 : 2'b01;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous overcurrent flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oc_meta <= 2'b00;
            r_oc_s    <= 2'b00;
        end else begin
            r_oc_meta <= OC;
            r_oc_s    <= r_oc_meta;
        end
    end

    // Free-running ramp prescaler; wraps at RAMP_DIV-1 and flags a tick there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Next-state, duty, timer and retry logic; a fault overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_dir_nx   = r_dir_q;
        w_timer_nx = r_timer;
        w_retry_nx = r_retry;

        case (r_state)
            S_IDLE: begin
                w_duty_nx = 12'd0;
                if (w_run) begin
                    w_state_nx = S_DEAD;
                    w_timer_nx = '0;
                end
            end

            S_DRIVE: begin
                if (w_tick) begin
                    w_duty_nx = w_ramp_duty;
                end
                // Direction change and run dropping both lead to a stop.
                if ((sw[1:0] != r_dir_q) || !w_run) begin
                    w_state_nx = S_STOPPING;
                end
            end

            S_STOPPING: begin
                if (r_duty == 12'd0) begin
                    w_state_nx = S_DEAD;
                    w_timer_nx = '0;
                end else if (w_tick) begin
                    w_duty_nx = w_ramp_duty;
                end
            end

            S_DEAD: begin
                w_duty_nx = 12'd0;
                if (r_timer == c_dead_last) begin
                    w_timer_nx = '0;
                    if (w_run) begin
                        w_dir_nx   = sw[1:0];
                        w_state_nx = S_DRIVE;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_timer_nx = r_timer + TIMER_W'(1);
                end
            end

            S_FAULT: begin
                w_duty_nx = 12'd0;
                // Cool-down only runs once the overcurrent has cleared.
                if (w_oc_any) begin
                    w_timer_nx = '0;
                end else if (r_timer == c_fault_last) begin
                    w_timer_nx = '0;
                    w_state_nx = (r_retry == c_retry_max) ? S_LOCKOUT : S_IDLE;
                end else begin
                    w_timer_nx = r_timer + TIMER_W'(1);
                end
            end

            S_LOCKOUT: begin
                w_duty_nx = 12'd0;
            end

            default: begin
                w_state_nx = S_IDLE;
                w_duty_nx  = 12'd0;
                w_timer_nx = '0;
            end
        endcase

        // Overcurrent entry takes priority over any transition or ramp step.
        if (w_oc_any && ((r_state == S_IDLE) || (r_state == S_DRIVE) ||
                         (r_state == S_STOPPING) || (r_state == S_DEAD))) begin
            w_state_nx = S_FAULT;
            w_duty_nx  = 12'd0;
            w_timer_nx = '0;
            w_dir_nx   = r_dir_q;
            w_retry_nx = (r_retry == 2'd3) ? 2'd3 : (r_retry + 2'd1);
        end
    end

    // Bridge controls derived from the next state so they are registered
    // in the same edge as the state itself.
    always_comb begin
        w_in_nx    = 4'b0000;
        w_en_nx    = 2'b00;
        w_fault_nx = 1'b0;
        case (w_state_nx)
            S_DRIVE, S_STOPPING: begin
                w_en_nx = 2'b11;
                w_in_nx = {bridge_pair(w_dir_nx[1]), bridge_pair(w_dir_nx[0])};
            end
            S_FAULT, S_LOCKOUT: begin
                w_fault_nx = 1'b1;
            end
            default: begin
                w_in_nx    = 4'b0000;
                w_en_nx    = 2'b00;
                w_fault_nx = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_duty  <= 12'd0;
            r_dir_q <= 2'b00;
            r_timer <= '0;
            r_retry <= 2'd0;
            r_in    <= 4'b0000;
            r_en    <= 2'b00;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_duty  <= w_duty_nx;
            r_dir_q <= w_dir_nx;
            r_timer <= w_timer_nx;
            r_retry <= w_retry_nx;
            r_in    <= w_in_nx;
            r_en    <= w_en_nx;
            r_fault <= w_fault_nx;
        end
    end

    assign duty      = r_duty;
    assign IN        = r_in;
    assign EN        = r_en;
    assign state     = r_state;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_motor_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_sequencer
//  Description : Directed self-checking bench for motor_sequencer with a
//                queue-based scoreboard of expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_motor_sequencer;

    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 16;
    localparam int DEAD_CYCLES = 8;
    localparam int FAULT_HOLD  = 20;
    localparam int MAX_RETRY   = 3;

    logic        clk;
    logic        rst;
    logic [7:0]  sw;
    logic [1:0]  OC;
    logic [11:0] duty;
    logic [3:0]  IN;
    logic [1:0]  EN;
    logic [2:0]  state;
    logic        fault;
    logic [1:0]  retry_cnt;

    int total;
    int bad;

    string       q_tag[$];
    logic [31:0] q_val[$];

    motor_sequencer #(
        .RAMP_DIV    (RAMP_DIV),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES),
        .FAULT_HOLD  (FAULT_HOLD),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .OC        (OC),
        .duty      (duty),
        .IN        (IN),
        .EN        (EN),
        .state     (state),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic [31:0] val);
        q_tag.push_back(tag);
        q_val.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (q_val.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_val.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic ck(input string tag, input logic [31:0] e, input logic [31:0] obs);
        exp_push(tag, e);
        chk(obs);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc);
        int n;
        n = 0;
        while ((state !== s) && (n < max_cyc)) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        int guard;
        int since;
        int n;
        int e;
        bit first;

        total = 0;
        bad   = 0;

        // ---------------- reset ----------------
        rst = 1'b1; sw = 8'hFF; OC = 2'b00;
        step(2);
        ck("reset_state", 0, state);
        ck("reset_duty",  0, duty);
        ck("reset_in",    0, IN);
        ck("reset_en",    0, EN);
        ck("reset_fault", 0, fault);
        ck("reset_retry", 0, retry_cnt);
        rst = 1'b0; sw = 8'h00;
        step(3);
        ck("idle_hold", 0, state);

        // ---------------- start ----------------
        sw = 8'b1001_0101;
        exp_push("start_dead", 3);
        exp_push("start_dead_en", 0);
        step(1);
        chk(state);
        chk(EN);
        step(7);
        ck("dead_last_cycle", 3, state);
        exp_push("drive_state", 1);
        exp_push("drive_en", 3);
        exp_push("drive_in", 4'b0110);
        exp_push("drive_duty0", 0);
        step(1);
        chk(state);
        chk(EN);
        chk(IN);
        chk(duty);

        prev = 0; guard = 0; since = 0; first = 1'b1;
        while ((duty != 12'd2295) && (guard < 1000)) begin
            step(1);
            guard++;
            since++;
            if (int'(duty) != prev) begin
                e = ((2295 - prev) > RAMP_STEP) ? prev + RAMP_STEP : 2295;
                ck("ramp_up", e, duty);
                if (!first) ck("ramp_up_rate", RAMP_DIV, since);
                first = 1'b0;
                since = 0;
                prev  = int'(duty);
            end
        end
        ck("ramp_up_final", 2295, duty);
        step(12);
        ck("ramp_up_hold", 2295, duty);
        ck("ramp_up_state", 1, state);

        // ---------------- speed drop ----------------
        sw = 8'b0001_0101;
        prev = 2295; guard = 0;
        while ((duty != 12'd255) && (guard < 1000)) begin
            step(1);
            guard++;
            if (int'(duty) != prev) begin
                e = ((prev - 255) > RAMP_STEP) ? prev - RAMP_STEP : 255;
                ck("ramp_down", e, duty);
                prev = int'(duty);
            end
        end
        ck("ramp_down_final", 255, duty);
        step(8);
        ck("ramp_down_hold", 255, duty);
        ck("ramp_down_state", 1, state);
        ck("ramp_down_in", 4'b0110, IN);

        // ---------------- reverse ----------------
        sw = 8'b0001_0100;
        exp_push("stop_state", 2);
        exp_push("stop_in", 4'b0110);
        exp_push("stop_en", 3);
        step(1);
        chk(state);
        chk(IN);
        chk(EN);
        wait_state(3'd3, 200);
        ck("rev_dead", 3, state);
        ck("rev_dead_duty", 0, duty);
        ck("rev_dead_in", 0, IN);
        ck("rev_dead_en", 0, EN);
        n = 0;
        while ((state === 3'd3) && (n < 50)) begin
            n++;
            step(1);
        end
        ck("rev_dead_len", DEAD_CYCLES, n);
        ck("rev_drive", 1, state);
        ck("rev_drive_in", 4'b0101, IN);
        ck("rev_drive_en", 3, EN);

        // ---------------- fault 1 (from DRIVE) ----------------
        OC = 2'b01;
        step(2);
        ck("f1_not_yet", 0, fault);
        step(1);
        ck("f1_state", 4, state);
        ck("f1_duty",  0, duty);
        ck("f1_en",    0, EN);
        ck("f1_fault", 1, fault);
        ck("f1_retry", 1, retry_cnt);
        OC = 2'b00;
        step(21);
        ck("f1_hold_state", 4, state);
        ck("f1_hold_fault", 1, fault);
        step(1);
        ck("f1_exit_state", 0, state);
        ck("f1_exit_fault", 0, fault);
        step(1);
        ck("f1_restart", 3, state);
        step(DEAD_CYCLES);
        ck("f1_redrive", 1, state);

        // ---------------- fault 2 (from DRIVE) ----------------
        OC = 2'b10;
        step(3);
        ck("f2_state", 4, state);
        ck("f2_retry", 2, retry_cnt);
        OC = 2'b00;
        wait_state(3'd0, 60);
        ck("f2_exit",  0, state);
        ck("f2_fault", 0, fault);
        step(1);
        ck("f3_dead", 3, state);

        // ---------------- fault 3 (from DEAD) -> lockout ----------------
        OC = 2'b11;
        step(3);
        ck("f3_state", 4, state);
        ck("f3_retry", 3, retry_cnt);
        OC = 2'b00;
        wait_state(3'd5, 60);
        ck("lock_state", 5, state);
        ck("lock_fault", 1, fault);
        sw = 8'h00; OC = 2'b11;
        step(5);
        OC = 2'b00; sw = 8'hF7;
        step(30);
        ck("lock_keep_state", 5, state);
        ck("lock_keep_fault", 1, fault);
        ck("lock_keep_en",    0, EN);
        ck("lock_keep_duty",  0, duty);
        ck("lock_keep_in",    0, IN);
        ck("lock_keep_retry", 3, retry_cnt);

        rst = 1'b1;
        step(1);
        rst = 1'b0; sw = 8'h00;
        ck("rst_state", 0, state);
        ck("rst_retry", 0, retry_cnt);
        ck("rst_fault", 0, fault);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
